// File: rtl/gpu_sched_pkg.sv
// Shared scheduler types: slot-state encoding and default wave-slot count.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gpu_sched_pkg;

    // Wave-slot lifecycle. The encoding is shared with the PC block.
    typedef enum logic [1:0] {
        SLOT_FREE    = 2'b00,
        SLOT_READY   = 2'b01,
        SLOT_WAITING = 2'b10
    } slot_state_e;

    // Slots per SIMD. The PC block sizes its context table from this value.
    localparam int DEFAULT_WAVES_PER_SIMD = 5;

endpackage

// File: rtl/wave_scheduler_rr_arbiter.sv
// Round-robin index picker: first set request after ptr, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; grant_valid is low when no request is set.
//
// Ports:
//   req         - request vector, one bit per index
//   ptr         - last granted index; the scan starts at ptr+1
//   grant       - chosen index (0 when grant_valid is low)
//   grant_valid - at least one request is set
module rr_arbiter #(
    parameter int N = 5,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] grant,
    output logic         grant_valid
);

    int idx;

    // Scan ptr+1 .. ptr+N. N need not be a power of two, so the wrap is an
    // explicit subtract rather than a truncation.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int i = 1; i <= N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!grant_valid && req[idx]) begin
                grant       = W'(idx);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wave_scheduler.sv
// Per-SIMD wave scheduler: slot table, dispatch allocation, round-robin issue.
// Latency: outputs are combinational; a dispatched wave can issue the next cycle.
// Backpressure: dispatch_ready drops when no slot is FREE; issue waits on issue_ready.
//
// Ports:
//   clk, rst                           - clock, synchronous active-high reset
//   dispatch_valid/ready, dispatch_slot - new-wave handshake and the slot it gets
//   issue_ready/valid                  - instruction issue handshake
//   active_context, UPDATE_PC,
//   DISPATCH_NEW_WAVE                  - PC block control (captured on the same edge)
//   stall/wake/done _valid + _ctx      - per-slot pipeline events
//   free_count, busy                   - occupancy status
module wave_scheduler
    import gpu_sched_pkg::*;
#(
    parameter int WAVES_PER_SIMD = DEFAULT_WAVES_PER_SIMD,
    parameter int CTX_W          = $clog2(WAVES_PER_SIMD)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                dispatch_valid,
    output logic                                dispatch_ready,
    output logic [CTX_W-1:0]                    dispatch_slot,
    input  logic                                issue_ready,
    output logic                                issue_valid,
    output logic [CTX_W-1:0]                    active_context,
    output logic                                UPDATE_PC,
    output logic                                DISPATCH_NEW_WAVE,
    input  logic                                stall_valid,
    input  logic [CTX_W-1:0]                    stall_ctx,
    input  logic                                wake_valid,
    input  logic [CTX_W-1:0]                    wake_ctx,
    input  logic                                done_valid,
    input  logic [CTX_W-1:0]                    done_ctx,
    output logic [$clog2(WAVES_PER_SIMD+1)-1:0] free_count,
    output logic                                busy
);

    localparam int FCW = $clog2(WAVES_PER_SIMD + 1);
    localparam logic [CTX_W-1:0] LAST_SLOT = CTX_W'(WAVES_PER_SIMD - 1);

    slot_state_e                slot_q [WAVES_PER_SIMD];
    logic [CTX_W-1:0]           rr_ptr;

    logic [WAVES_PER_SIMD-1:0]  free_vec;
    logic [WAVES_PER_SIMD-1:0]  elig_vec;
    logic [WAVES_PER_SIMD-1:0]  stall_hit;
    logic [WAVES_PER_SIMD-1:0]  wake_hit;
    logic [WAVES_PER_SIMD-1:0]  done_hit;

    logic [CTX_W-1:0]           free_slot;
    logic                       free_any;
    logic [CTX_W-1:0]           issue_grant;
    logic                       issue_any;
    logic                       dispatch_fire;
    logic                       issue_fire;
    logic [FCW-1:0]             free_cnt;

    // Decode events into per-slot hit vectors; a slot stalled or finishing
    // this cycle must not be granted, so eligibility masks them out.
    always_comb begin
        free_vec  = '0;
        elig_vec  = '0;
        stall_hit = '0;
        wake_hit  = '0;
        done_hit  = '0;
        for (int i = 0; i < WAVES_PER_SIMD; i++) begin
            stall_hit[i] = stall_valid && (stall_ctx == CTX_W'(i));
            wake_hit[i]  = wake_valid  && (wake_ctx  == CTX_W'(i));
            done_hit[i]  = done_valid  && (done_ctx  == CTX_W'(i));
            free_vec[i]  = (slot_q[i] == SLOT_FREE);
            elig_vec[i]  = (slot_q[i] == SLOT_READY) && !stall_hit[i] && !done_hit[i];
        end
    end

    // Lowest-index FREE slot: the same arbiter with the pointer parked on the
    // last slot, so the scan always begins at slot 0.
    rr_arbiter #(
        .N (WAVES_PER_SIMD),
        .W (CTX_W)
    ) u_free_pick (
        .req         (free_vec),
        .ptr         (LAST_SLOT),
        .grant       (free_slot),
        .grant_valid (free_any)
    );

    rr_arbiter #(
        .N (WAVES_PER_SIMD),
        .W (CTX_W)
    ) u_issue_pick (
        .req         (elig_vec),
        .ptr         (rr_ptr),
        .grant       (issue_grant),
        .grant_valid (issue_any)
    );

    always_comb begin
        free_cnt = '0;
        for (int i = 0; i < WAVES_PER_SIMD; i++) begin
            free_cnt = free_cnt + FCW'(free_vec[i]);
        end
    end

    // Dispatch and issue share the PC port; dispatch wins.
    assign dispatch_ready = !rst && free_any;
    assign dispatch_fire  = dispatch_valid && dispatch_ready;
    assign issue_fire     = !rst && !dispatch_fire && issue_ready && issue_any;

    assign dispatch_slot     = rst ? '0 : free_slot;
    assign issue_valid       = issue_fire;
    assign UPDATE_PC         = issue_fire;
    assign DISPATCH_NEW_WAVE = dispatch_fire;
    assign free_count        = rst ? FCW'(WAVES_PER_SIMD) : free_cnt;
    assign busy              = !rst && !(&free_vec);

    always_comb begin
        if (rst) begin
            active_context = '0;
        end else if (dispatch_fire) begin
            active_context = free_slot;
        end else if (issue_fire) begin
            active_context = issue_grant;
        end else begin
            active_context = rr_ptr;
        end
    end

    // Slot state transitions. done beats stall/wake; a wake alongside a stall
    // cancels it. Dispatch only lands on FREE slots, where events are no-ops.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= LAST_SLOT;
            for (int i = 0; i < WAVES_PER_SIMD; i++) begin
                slot_q[i] <= SLOT_FREE;
            end
        end else begin
            if (issue_fire) begin
                rr_ptr <= issue_grant;
            end
            for (int i = 0; i < WAVES_PER_SIMD; i++) begin
                unique case (slot_q[i])
                    SLOT_FREE: begin
                        if (dispatch_fire && (free_slot == CTX_W'(i))) begin
                            slot_q[i] <= SLOT_READY;
                        end
                    end
                    SLOT_READY: begin
                        if (done_hit[i]) begin
                            slot_q[i] <= SLOT_FREE;
                        end else if (stall_hit[i] && !wake_hit[i]) begin
                            slot_q[i] <= SLOT_WAITING;
                        end
                    end
                    SLOT_WAITING: begin
                        if (done_hit[i]) begin
                            slot_q[i] <= SLOT_FREE;
                        end else if (wake_hit[i]) begin
                            slot_q[i] <= SLOT_READY;
                        end
                    end
                    default: slot_q[i] <= SLOT_FREE;
                endcase
            end
        end
    end

endmodule

// File: doc/wave_scheduler.md
# wave_scheduler

Per-SIMD wavefront scheduler: owns the wave-slot table for one SIMD unit, accepts new waves from the dispatcher, and picks one ready wave per cycle round-robin for instruction issue. It drives the per-wave PC block directly (`active_context`, `UPDATE_PC`, `DISPATCH_NEW_WAVE`) and tracks each slot through FREE/READY/WAITING as stall, wake and done events arrive from the pipeline.

## Interface

Parameters:
- `WAVES_PER_SIMD`, 5: number of wave slots. Must match the PC block.
- `CTX_W`, `$clog2(WAVES_PER_SIMD)`: slot index width.

Ports:
- `clk`, input, 1: clock. All state updates on the rising edge.
- `rst`, input, 1: reset. Synchronous, active-high.
- `dispatch_valid`, input, 1: dispatcher offers a new wave.
- `dispatch_ready`, output, 1: at least one FREE slot exists and `rst` is low.
- `dispatch_slot`, output, CTX_W: slot that an accepted wave is given. This is the lowest-index FREE slot.
- `issue_ready`, input, 1: pipeline can accept an instruction this cycle.
- `issue_valid`, output, 1: a wave is issued this cycle.
- `active_context`, output, CTX_W: slot presented to the PC block.
- `UPDATE_PC`, output, 1: advance the PC of `active_context`. Equals `issue_valid`.
- `DISPATCH_NEW_WAVE`, output, 1: zero the PC of `active_context`.
- `stall_valid`, input, 1: a wave must wait, for example on a memory load.
- `stall_ctx`, input, CTX_W: slot that `stall_valid` applies to.
- `wake_valid`, input, 1: a waiting wave may resume.
- `wake_ctx`, input, CTX_W: slot that `wake_valid` applies to.
- `done_valid`, input, 1: a wave has finished its program.
- `done_ctx`, input, CTX_W: slot that `done_valid` applies to.
- `free_count`, output, `$clog2(WAVES_PER_SIMD+1)`: number of FREE slots.
- `busy`, output, 1: at least one slot is not FREE.

## Operation

- Each slot holds a 2-bit state: FREE, READY or WAITING. There is also an `rr_ptr` register (CTX_W bits) holding the last issued slot.
- **Reset:**
  - All slots go to FREE and `rr_ptr` goes to `WAVES_PER_SIMD-1`, so slot 0 is scanned first.
  - All outputs are 0 while `rst` is high, except `free_count`, which is `WAVES_PER_SIMD`.
- **Dispatch:** occurs when `dispatch_valid && dispatch_ready`.
  - The slot `dispatch_slot` moves FREE→READY.
  - In the same cycle: `DISPATCH_NEW_WAVE=1`, `active_context=dispatch_slot`, `issue_valid=0`.
  - Dispatch has priority over issue because the two share the PC port.
- **Issue:** occurs when there is no dispatch this cycle, `issue_ready=1`, and at least one slot is eligible.
  - A slot is eligible if it is READY and is not named by a `stall_valid` or `done_valid` in the same cycle.
  - The grant is the first eligible slot scanning `rr_ptr+1, rr_ptr+2, …`, wrapping modulo `WAVES_PER_SIMD`. This is not a power-of-two wrap.
  - Outputs: `issue_valid=1`, `UPDATE_PC=1`, `active_context=grant`.
  - `rr_ptr` becomes `grant` on the next edge.
- **Idle:** when neither dispatch nor issue occurs, `UPDATE_PC=0`, `DISPATCH_NEW_WAVE=0`, `active_context=rr_ptr`.
- **Events,** applied on the edge:
  - stall: READY→WAITING.
  - wake: WAITING→READY.
  - done: any non-FREE state→FREE.
  - An event naming a slot in a non-matching state is ignored, e.g. wake on READY, or stall/done on FREE.
- **Same-slot collisions in one cycle:**
  - done beats stall and wake.
  - stall+wake on the same slot leaves it READY.
  - A dispatch can never collide with an event, because dispatch only targets FREE slots.
- **Different slots:** all events in a cycle apply independently.
- A slot freed by done becomes dispatchable on the next cycle; `dispatch_ready` does not look ahead.

## Timing

- Outputs are combinational from registered state plus the current-cycle inputs. The PC block therefore captures `active_context`/`UPDATE_PC`/`DISPATCH_NEW_WAVE` on the same edge the scheduler commits.
- Dispatch→first issue of that wave: the earliest issue is the cycle after acceptance.
- Stall takes effect the same cycle (that slot cannot issue). Wake lets the slot issue on the next cycle.
- Throughput: at most one dispatch or one issue per cycle.
- **Reset mid-operation:**
  - All state clears on the next edge.
  - Inputs are ignored during `rst`, and no handshake completes.
  - In-flight waves are lost; re-dispatching them is the dispatcher's job.

## Structure

- Shared package `gpu_sched_pkg` holds:
  - the slot-state enum: FREE=2'b00, READY=2'b01, WAITING=2'b10.
  - the `WAVES_PER_SIMD` default, shared with the PC block.
- Sub-module `rr_arbiter #(N)`. It is purely combinational:
  - inputs: request vector and pointer.
  - outputs: grant index and `grant_valid`.
- The same `rr_arbiter` is reused for the lowest-index FREE search with the pointer tied to N-1.
- The scheduler top holds the slot table, `rr_ptr` and the event/priority logic.

## Test plan

- **Reset then fill:** `rst` 1 cycle, then `dispatch_valid` held 6 cycles.
  - Slots 0..4 are allocated in order, each with `DISPATCH_NEW_WAVE=1`.
  - The 6th cycle sees `dispatch_ready=0`.
  - `free_count` goes 5→0.
- **Round-robin fairness:** slots 0,1,2 READY, `issue_ready=1` for 6 cycles → `active_context` sequence 0,1,2,0,1,2 with `UPDATE_PC=1` on each.
- **Stall/wake:** slots 0,1 READY. Stall slot 1 in the same cycle it would be granted → grant goes to 0. Slot 1 is skipped until the wake, then issues the cycle after the wake.
- **Dispatch priority:** slot 0 READY, `issue_ready=1`, dispatch accepted → `issue_valid=0`, `DISPATCH_NEW_WAVE=1`, `active_context=1`. Slot 0 issues the next cycle.
- **Collisions:**
  - done+stall on slot 2 in one cycle → slot 2 FREE.
  - stall+wake on slot 3 in one cycle → slot 3 READY.
  - wake on a FREE slot → no change.
- **Mid-run reset:** 3 waves live, some WAITING; assert `rst` → next cycle all FREE, `free_count=5`, `busy=0`, and the first subsequent dispatch gets slot 0.
